// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router packet FIFO slice.
//   DATA_W_DEF : default byte width of the data path
//   LEN_LSB    : lowest bit of the payload-length field inside a header byte
//   router_entry_t : one stored FIFO entry {lfd, data} at the default width
// ---------------------------------------------------------------------------
package router_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_LSB    = 2;

    typedef struct packed {
        logic                  lfd;
        logic [DATA_W_DEF-1:0] data;
    } router_entry_t;

endpackage : router_pkg

// File: rtl/router_fifo_mem.sv
// ---------------------------------------------------------------------------
// router_fifo_mem
// Simple dual-port storage array: one write port, one registered read port.
//   clk       : rising-edge clock
//   wr_en_i   : write strobe, stores wr_data_i at wr_addr_i
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_en_i   : read strobe, captures the word at rd_addr_i
//   rd_addr_i : read address
//   rd_data_o : registered read data, held while rd_en_i is low
// ---------------------------------------------------------------------------
module router_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // NOTE: storage and its read register carry no reset, so they map onto
    // plain RAM; the owner masks the read data until a real read has happened.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : router_fifo_mem

// File: rtl/router_pkt_fifo.sv
// ---------------------------------------------------------------------------
// router_pkt_fifo
// Packet-aware byte FIFO. Each entry is {lfd_state, data_in}. On the read
// side a header entry loads a remaining-byte count (length field + 1 for the
// parity byte); following bytes decrement it. Protocol violations set a
// sticky hdr_err.
//   clk, resetn         : clock, synchronous active-low reset
//   soft_reset          : synchronous flush, active-high
//   write_enb/lfd_state/data_in : write request, header mark, write data
//   read_enb            : read request
//   data_out            : registered read data (1-cycle latency)
//   empty/full/fill_level : occupancy status
//   pkt_busy            : packet bytes still outstanding on the read side
//   hdr_err             : sticky protocol-error flag
// ---------------------------------------------------------------------------
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic                     lfd_state,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     read_enb,
    output logic [DATA_W-1:0]        data_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     pkt_busy,
    output logic                     hdr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = DATA_W - 1;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_now, hdr_len;
    logic          err_q, err_d, err_now;
    logic          pend_q, pend_d;   // a read was accepted last edge, entry now on rd_entry
    logic          ovld_q, ovld_d;   // read register holds a genuinely read entry
    logic          run, wr_acc, rd_acc;
    logic [DATA_W:0]   rd_entry;
    logic              rd_lfd;
    logic [DATA_W-1:0] rd_data;

    router_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wptr_q),
        .wr_data_i ({lfd_state, data_in}),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rptr_q),
        .rd_data_o (rd_entry)
    );

    assign rd_lfd  = rd_entry[DATA_W];
    assign rd_data = rd_entry[DATA_W-1:0];
    assign hdr_len = CW'(rd_data[DATA_W-1:LEN_LSB]) + CW'(1);

    // Status comes straight from the fill counter, so full/empty never
    // depend on comparing wrapped pointers.
    assign empty      = (fill_q == '0);
    assign full       = (fill_q == (AW+1)'(DEPTH));
    assign fill_level = fill_q;

    // The entry read at an edge only appears on rd_entry after it, so the
    // packet counter is resolved here from the held count plus that entry.
    // This keeps pkt_busy/hdr_err aligned with data_out.
    // NOTE: every output of this block gets a default first, so no latch
    // can be inferred on the paths where no branch assigns it.
    always_comb begin
        cnt_now = cnt_q;
        err_now = err_q;
        if (pend_q) begin
            if (rd_lfd) begin
                if (cnt_q != '0) begin
                    err_now = 1'b1;
                end
                cnt_now = hdr_len;
            end else if (cnt_q != '0) begin
                cnt_now = cnt_q - CW'(1);
            end else begin
                err_now = 1'b1;
            end
        end
    end

    assign pkt_busy = (cnt_now != '0);
    assign hdr_err  = err_now;
    assign data_out = ovld_q ? rd_data : '0;

    // Both resets outrank traffic, so no transfer is accepted while either is active.
    assign run    = resetn && !soft_reset;
    assign wr_acc = run && write_enb && !full;
    assign rd_acc = run && read_enb && !empty;

    always_comb begin
        wptr_d = wr_acc ? wptr_q + AW'(1) : wptr_q;
        rptr_d = rd_acc ? rptr_q + AW'(1) : rptr_q;
        fill_d = fill_q;
        if (wr_acc && !rd_acc) begin
            fill_d = fill_q + (AW+1)'(1);
        end else if (rd_acc && !wr_acc) begin
            fill_d = fill_q - (AW+1)'(1);
        end
        cnt_d  = cnt_now;
        err_d  = err_now;
        pend_d = rd_acc;
        ovld_d = ovld_q || rd_acc;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn || soft_reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            pend_q <= 1'b0;
            ovld_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            pend_q <= pend_d;
            ovld_q <= ovld_d;
        end
    end

endmodule : router_pkt_fifo

// File: tb/tb_router_pkt_fifo.sv
// ---------------------------------------------------------------------------
// tb_router_pkt_fifo
// Self-checking bench: a queue-based reference model updated on each rising
// edge, one compare process on each falling edge, directed scenarios with
// literal expectations, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_router_pkt_fifo;
    import router_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          soft_reset = 1'b0;
    logic          write_enb = 1'b0;
    logic          lfd_state = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          read_enb = 1'b0;
    logic [DW-1:0] data_out;
    logic          empty, full, pkt_busy, hdr_err;
    logic [4:0]    fill_level;

    int n_cmp = 0;
    int n_bad = 0;

    router_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full),
        .fill_level (fill_level),
        .pkt_busy   (pkt_busy),
        .hdr_err    (hdr_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    router_entry_t q[$];
    int  m_dout = 0;
    int  m_cnt  = 0;
    bit  m_err  = 0;
    bit  m_valid = 0;

    always @(posedge clk) begin
        router_entry_t e;
        bit do_wr, do_rd;
        if (!resetn) begin
            q.delete();
            m_dout = 0; m_cnt = 0; m_err = 0;
            m_valid = 1;
        end else if (soft_reset) begin
            q.delete();
            m_dout = 0; m_cnt = 0; m_err = 0;
        end else begin
            do_wr = write_enb && (q.size() < DEPTH);
            do_rd = read_enb && (q.size() > 0);
            if (do_rd) begin
                e = q.pop_front();
                m_dout = int'(e.data);
                if (e.lfd) begin
                    if (m_cnt != 0) m_err = 1;
                    m_cnt = int'(e.data) / 4 + 1;
                end else if (m_cnt != 0) begin
                    m_cnt = m_cnt - 1;
                end else begin
                    m_err = 1;
                end
            end
            if (do_wr) begin
                e.lfd  = lfd_state;
                e.data = data_in;
                q.push_back(e);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("data_out",   int'(data_out),   m_dout);
            check("fill_level", int'(fill_level), q.size());
            check("empty",      int'(empty),      int'(q.size() == 0));
            check("full",       int'(full),       int'(q.size() == DEPTH));
            check("pkt_busy",   int'(pkt_busy),   int'(m_cnt != 0));
            check("hdr_err",    int'(hdr_err),    int'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic wr, input logic lfd, input logic [DW-1:0] d,
                         input logic rd, input logic sr);
        write_enb  = wr;
        lfd_state  = lfd;
        data_in    = d;
        read_enb   = rd;
        soft_reset = sr;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [DW-1:0] exp_b;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        check("rst_fill",  int'(fill_level), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_dout",  int'(data_out), 0);
        check("rst_busy",  int'(pkt_busy), 0);

        // Header 0x0C (length 3) plus 3 payload bytes and parity.
        drive(1, 1, 8'h0C, 0, 0);
        for (int i = 1; i <= 4; i++) drive(1, 0, 8'hA0 + DW'(i), 0, 0);
        drive(0, 0, '0, 1, 0);
        check("pkt_hdr_dout", int'(data_out), 'h0C);
        check("pkt_busy_1",   int'(pkt_busy), 1);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, '0, 1, 0);
            exp_b = 8'hA0 + DW'(i);
            check("pkt_byte", int'(data_out), int'(exp_b));
            check("pkt_busy_n", int'(pkt_busy), (i < 4) ? 1 : 0);
        end
        check("pkt_empty", int'(empty), 1);
        check("pkt_err",   int'(hdr_err), 0);

        // Fill to DEPTH, try one more, then drain in order.
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 8'h30 + DW'(i), 0, 0);
        check("full_flag", int'(full), 1);
        check("full_fill", int'(fill_level), 16);
        drive(1, 0, 8'hEE, 0, 0);
        check("full_drop", int'(fill_level), 16);
        for (int i = 0; i < DEPTH; i++) drive(0, 0, '0, 1, 0);
        check("drain_last", int'(data_out), 'h3F);
        check("drain_empty", int'(empty), 1);
        flush();

        // Full with simultaneous read and write: only the read goes through.
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 8'h40 + DW'(i), 0, 0);
        drive(1, 0, 8'h77, 1, 0);
        check("rw_full_fill", int'(fill_level), 15);
        check("rw_full_dout", int'(data_out), 'h40);
        for (int i = 0; i < DEPTH - 1; i++) drive(0, 0, '0, 1, 0);
        check("rw_drained", int'(data_out), 'h4F);

        // Empty with simultaneous read and write: only the write goes through.
        drive(1, 0, 8'h99, 1, 0);
        check("rw_empty_fill", int'(fill_level), 1);
        check("rw_empty_dout", int'(data_out), 'h4F);
        drive(0, 0, '0, 1, 0);
        check("rw_empty_rd", int'(data_out), 'h99);
        flush();

        // Header arriving while a packet is still open.
        drive(1, 1, 8'h08, 0, 0);
        drive(1, 0, 8'h11, 0, 0);
        drive(1, 1, 8'h04, 0, 0);
        drive(1, 0, 8'h22, 0, 0);
        drive(0, 0, '0, 1, 0);
        drive(0, 0, '0, 1, 0);
        check("early_hdr_noerr", int'(hdr_err), 0);
        drive(0, 0, '0, 1, 0);
        check("early_hdr_err",  int'(hdr_err), 1);
        check("early_hdr_busy", int'(pkt_busy), 1);
        drive(0, 0, '0, 1, 0);
        check("reload_busy", int'(pkt_busy), 1);
        idle();
        check("err_sticky", int'(hdr_err), 1);

        // Flush in the middle of a packet, then stream 40 bytes through.
        flush();
        drive(1, 1, 8'h0C, 0, 0);
        drive(1, 0, 8'h01, 0, 0);
        drive(1, 0, 8'h02, 0, 0);
        drive(0, 0, '0, 1, 0);
        drive(0, 0, '0, 1, 0);
        flush();
        check("sr_fill", int'(fill_level), 0);
        check("sr_busy", int'(pkt_busy), 0);
        check("sr_err",  int'(hdr_err), 0);
        check("sr_dout", int'(data_out), 0);
        for (int i = 0; i < 40; i++) drive(1, (i % 8) == 0, DW'(i * 4 + 1), i > 0, 0);
        check("wrap_dout", int'(data_out), 38 * 4 + 1);
        check("wrap_fill", int'(fill_level), 1);

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic wr, rd, lf, sr;
            int bias;
            bias = (i / 500) % 2;   // alternate write-heavy and read-heavy phases
            wr = ($urandom_range(99) < (bias ? 40 : 70));
            rd = ($urandom_range(99) < (bias ? 70 : 40));
            lf = ($urandom_range(99) < 20);
            sr = ($urandom_range(199) == 0);
            resetn = ($urandom_range(299) != 0);
            drive(wr, lf, DW'($urandom), rd, sr);
        end
        resetn = 1'b1;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_router_pkt_fifo

// File: doc/router_pkt_fifo.md
ROUTER_PKT_FIFO -- requirements
Module: router_pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_W, 8, byte width of data path (>=3).
REQ-002 SHALL have parameter DEPTH, 16, entry count (power of 2, >=4).
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port resetn  in  1  synchronous, active-low reset.
REQ-005 SHALL have port soft_reset  in  1  synchronous flush, active-high.
REQ-006 SHALL have port write_enb  in  1  write request.
REQ-007 SHALL have port lfd_state  in  1  marks data_in as packet header.
REQ-008 SHALL have port data_in  in  DATA_W  write data.
REQ-009 SHALL have port read_enb  in  1  read request.
REQ-010 SHALL have port data_out  out  DATA_W  registered read data.
REQ-011 SHALL have port empty  out  1  high when fill level is 0.
REQ-012 SHALL have port full  out  1  high when fill level is DEPTH.
REQ-013 SHALL have port fill_level  out  clog2(DEPTH)+1  stored entry count.
REQ-014 SHALL have port pkt_busy  out  1  high while a read packet has bytes left.
REQ-015 SHALL have port hdr_err  out  1  sticky protocol-error flag.

Function
REQ-016 SHALL store each entry as {lfd_state, data_in}, DATA_W+1 bits.
REQ-017 SHALL accept a write only when write_enb=1 and full=0; write pointer increments, wraps DEPTH-1 -> 0.
REQ-018 SHALL accept a read only when read_enb=1 and empty=0; data_out updates on the same clock edge (1-cycle latency); read pointer wraps DEPTH-1 -> 0.
REQ-019 SHALL block writes when full=1 even if a read occurs that cycle; SHALL block reads when empty=1 even if a write occurs that cycle.
REQ-020 SHALL leave fill_level unchanged on a simultaneous accepted read and write; +1 on write-only, -1 on read-only.
REQ-021 SHALL derive empty and full combinationally from fill_level (no pointer-equality ambiguity).
REQ-022 On reading an entry with lfd bit=1, SHALL load remaining-count = header[DATA_W-1:2] + 1 (payload + parity), counter width DATA_W-1 bits, no overflow.
REQ-023 On reading an entry with lfd bit=0 and remaining-count>0, SHALL decrement remaining-count.
REQ-024 pkt_busy SHALL equal (remaining-count != 0).
REQ-025 On reading a header while remaining-count != 0, SHALL set hdr_err and reload count from the new header.
REQ-026 On reading a non-header entry while remaining-count == 0, SHALL set hdr_err and leave count at 0.
REQ-027 SHALL hold data_out when no read is accepted.
REQ-028 soft_reset SHALL clear pointers, fill_level, remaining-count, data_out and hdr_err; storage contents need not be cleared.

Reset
REQ-029 On resetn=0 at a clock edge, SHALL set data_out=0, fill_level=0, empty=1, full=0, pkt_busy=0, hdr_err=0, pointers=0.
REQ-030 resetn SHALL take priority over soft_reset, which takes priority over read/write; mid-packet reset discards all state.

Structure
REQ-031 Shared package router_pkg SHALL hold DATA_W default, length-field LSB index (2), and the entry type {lfd, data}.
REQ-032 Storage array SHALL be sub-module router_fifo_mem (1 write port, 1 read port, registered read, no reset).

Verification
REQ-033 Reset then write header 0x0C (len 3) + 4 bytes, read 5 -> data_out 0x0C,b1..b4; pkt_busy high 4 cycles then 0; empty=1.
REQ-034 Write 16 entries (DEPTH=16) -> full=1, fill_level=16; 17th write ignored; read all -> original order, empty=1.
REQ-035 Fill to 16, assert read and write same cycle -> read accepted, write dropped, fill_level=15.
REQ-036 Empty FIFO, read and write same cycle -> read ignored, fill_level=1, data_out unchanged.
REQ-037 Read header 0x08 (len 2), then header 0x04 before 3 bytes consumed -> hdr_err=1, count reloads to 2.
REQ-038 Mid-packet soft_reset -> next cycle fill_level=0, pkt_busy=0, hdr_err=0, data_out=0; pointers wrap correctly over 40 later writes.
